// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: sequencing controller for the multicycle MIPS datapath with memory wait states, halt and trap.
module multicycle_control_fsm #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [5:0]             opcode,
  input  logic                   mem_ready,
  input  logic                   halt_req,
  output logic                   pc_write,
  output logic                   pc_write_cond,
  output logic                   iord,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   ir_write,
  output logic                   mem_to_reg,
  output logic                   reg_dst,
  output logic                   reg_write,
  output logic                   alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic [1:0]             alu_op,
  output logic [1:0]             pc_source,
  output logic [3:0]             state,
  output logic                   instr_retired,
  output logic [COUNT_WIDTH-1:0] retired_count,
  output logic                   halted,
  output logic                   trap
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
    MEMWR = 4'd5, EXEC = 4'd6, RWB = 4'd7, BRANCH = 4'd8, JUMP = 4'd9,
    ADDI_EX = 4'd10, ADDI_WB = 4'd11, TRAP = 4'd12, HALT = 4'd13
  } state_t;
  localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] OP_BEQ = 6'h04, OP_J = 6'h02, OP_ADDI = 6'h08;
  state_t st, nxt;
  logic   retire;
  assign state = st;
  assign retire = (st inside {MEMWB, RWB, BRANCH, JUMP, ADDI_WB}) || (st == MEMWR && mem_ready);
  always_ff @(posedge clk or negedge reset)
    if (!reset) st <= FETCH;
    else st <= nxt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) retired_count <= '0;
    else if (retire) retired_count <= retired_count + COUNT_WIDTH'(1);
  always_comb begin
    nxt = st;
    case (st)
      FETCH:   nxt = mem_ready ? DECODE : FETCH;
      DECODE:  nxt = opcode == OP_R ? EXEC :
                     (opcode == OP_LW || opcode == OP_SW) ? MEMADR :
                     opcode == OP_BEQ ? BRANCH :
                     opcode == OP_J ? JUMP :
                     opcode == OP_ADDI ? ADDI_EX : TRAP;
      MEMADR:  nxt = opcode == OP_LW ? MEMRD : MEMWR;
      MEMRD:   nxt = mem_ready ? MEMWB : MEMRD;
      EXEC:    nxt = RWB;
      ADDI_EX: nxt = ADDI_WB;
      MEMWB, MEMWR, RWB, BRANCH, JUMP, ADDI_WB:
               nxt = retire ? (halt_req ? HALT : FETCH) : st;
      HALT:    nxt = halt_req ? HALT : FETCH;
      default: nxt = TRAP;
    endcase
  end
  // Everything is forced low while reset is held so no strobe can glitch during an abort.
  always_comb begin
    pc_write = 1'b0;
    pc_write_cond = 1'b0;
    iord = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    ir_write = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst = 1'b0;
    reg_write = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    alu_op = 2'b00;
    pc_source = 2'b00;
    halted = 1'b0;
    trap = 1'b0;
    instr_retired = reset && retire;
    if (reset)
      case (st)
        FETCH: begin
          mem_read = 1'b1;
          alu_src_b = 2'b01;
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        DECODE:  alu_src_b = 2'b11;
        MEMADR, ADDI_EX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        MEMRD: begin
          iord = 1'b1;
          mem_read = 1'b1;
        end
        MEMWB: begin
          mem_to_reg = 1'b1;
          reg_write = 1'b1;
        end
        MEMWR: begin
          iord = 1'b1;
          mem_write = 1'b1;
        end
        EXEC: begin
          alu_src_a = 1'b1;
          alu_op = 2'b10;
        end
        RWB: begin
          reg_dst = 1'b1;
          reg_write = 1'b1;
        end
        BRANCH: begin
          alu_src_a = 1'b1;
          alu_op = 2'b01;
          pc_write_cond = 1'b1;
          pc_source = 2'b01;
        end
        JUMP: begin
          pc_write = 1'b1;
          pc_source = 2'b10;
        end
        ADDI_WB: reg_write = 1'b1;
        HALT:    halted = 1'b1;
        default: trap = 1'b1;
      endcase
  end
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: directed vector table, multi-cycle corner sequences and a randomized route-based reference model.
module tb_multicycle_control_fsm;
  logic clk = 0, reset = 0, mem_ready = 0, halt_req = 0;
  logic [5:0] opcode = 6'h00;
  logic pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;
  logic instr_retired, halted, trap;
  logic [31:0] retired_count;
  logic pc_write_4, pc_write_cond_4, iord_4, mem_read_4, mem_write_4, ir_write_4, mem_to_reg_4, reg_dst_4, reg_write_4, alu_src_a_4;
  logic [1:0] alu_src_b_4, alu_op_4, pc_source_4;
  logic [3:0] state_4, retired_count_4;
  logic instr_retired_4, halted_4, trap_4;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  multicycle_control_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready), .halt_req(halt_req),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state(state), .instr_retired(instr_retired),
    .retired_count(retired_count), .halted(halted), .trap(trap));
  multicycle_control_fsm #(.COUNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready), .halt_req(halt_req),
    .pc_write(pc_write_4), .pc_write_cond(pc_write_cond_4), .iord(iord_4), .mem_read(mem_read_4),
    .mem_write(mem_write_4), .ir_write(ir_write_4), .mem_to_reg(mem_to_reg_4), .reg_dst(reg_dst_4),
    .reg_write(reg_write_4), .alu_src_a(alu_src_a_4), .alu_src_b(alu_src_b_4), .alu_op(alu_op_4),
    .pc_source(pc_source_4), .state(state_4), .instr_retired(instr_retired_4),
    .retired_count(retired_count_4), .halted(halted_4), .trap(trap_4));
  wire [17:0] ctrl = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
                      reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, halted, trap};
  wire [2:0] wr = {ir_write, mem_write, reg_write};
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    else passed++;
  endtask
  // Control word each state should present, read straight off the state descriptions.
  function automatic logic [17:0] exp_ctrl(int s, logic mr);
    logic pw = 0, pwc = 0, io = 0, mrd = 0, mw = 0, irw = 0, m2r = 0, rd = 0, rw = 0, sa = 0, ha = 0, tr = 0;
    logic [1:0] sb = 0, op = 0, ps = 0;
    case (s)
      0:  begin mrd = 1; sb = 2'b01; irw = mr; pw = mr; end
      1:  sb = 2'b11;
      2:  begin sa = 1; sb = 2'b10; end
      3:  begin io = 1; mrd = 1; end
      4:  begin m2r = 1; rw = 1; end
      5:  begin io = 1; mw = 1; end
      6:  begin sa = 1; op = 2'b10; end
      7:  begin rd = 1; rw = 1; end
      8:  begin sa = 1; op = 2'b01; pwc = 1; ps = 2'b01; end
      9:  begin pw = 1; ps = 2'b10; end
      10: begin sa = 1; sb = 2'b10; end
      11: rw = 1;
      12: tr = 1;
      default: ha = 1;
    endcase
    return {pw, pwc, io, mrd, mw, irw, m2r, rd, rw, sa, sb, op, ps, ha, tr};
  endfunction
  typedef struct {
    logic [5:0] op; logic mr; logic hr;
    logic [3:0] st; logic ret; logic [2:0] wr; logic [31:0] cnt;
  } vec_t;
  vec_t tbl[$];
  task automatic v(logic [5:0] op, logic mr, logic hr, logic [3:0] st, logic ret, logic [2:0] w, logic [31:0] cnt);
    tbl.push_back('{op, mr, hr, st, ret, w, cnt});
  endtask
  // Reference model: each instruction is a fixed route of states; wait-capable steps repeat until mem_ready.
  int rt[5];
  int rl, ix, tcyc;
  bit mhalt;
  logic [31:0] mcnt;
  task automatic new_instr();
    logic [5:0] ops[6] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
    opcode = ($urandom_range(0, 99) < 3) ? 6'h3F : ops[$urandom_range(0, 5)];
    case (opcode)
      6'h00:   begin rt = '{0, 1, 6, 7, 0}; rl = 4; end
      6'h23:   begin rt = '{0, 1, 2, 3, 4}; rl = 5; end
      6'h2B:   begin rt = '{0, 1, 2, 5, 0}; rl = 4; end
      6'h04:   begin rt = '{0, 1, 8, 0, 0}; rl = 3; end
      6'h02:   begin rt = '{0, 1, 9, 0, 0}; rl = 3; end
      6'h08:   begin rt = '{0, 1, 10, 11, 0}; rl = 4; end
      default: begin rt = '{0, 1, 12, 0, 0}; rl = 3; end
    endcase
    ix = 0;
    mhalt = 0;
  endtask
  initial begin
    int es;
    bit last, eret, nw;
    // R-type, lw with waits, sw with waits, beq, j, R-type with halt
    v(6'h00,1,0, 0,0,3'b100,0); v(6'h00,1,0, 1,0,3'b000,0); v(6'h00,1,0, 6,0,3'b000,0); v(6'h00,1,0, 7,1,3'b001,0);
    v(6'h23,0,0, 0,0,3'b000,1); v(6'h23,0,0, 0,0,3'b000,1); v(6'h23,1,0, 0,0,3'b100,1); v(6'h23,1,0, 1,0,3'b000,1);
    v(6'h23,1,0, 2,0,3'b000,1); v(6'h23,0,0, 3,0,3'b000,1); v(6'h23,0,0, 3,0,3'b000,1); v(6'h23,0,0, 3,0,3'b000,1);
    v(6'h23,1,0, 3,0,3'b000,1); v(6'h23,1,0, 4,1,3'b001,1);
    v(6'h2B,1,0, 0,0,3'b100,2); v(6'h2B,1,0, 1,0,3'b000,2); v(6'h2B,1,0, 2,0,3'b000,2);
    v(6'h2B,0,0, 5,0,3'b010,2); v(6'h2B,0,0, 5,0,3'b010,2); v(6'h2B,1,0, 5,1,3'b010,2);
    v(6'h04,1,0, 0,0,3'b100,3); v(6'h04,1,0, 1,0,3'b000,3); v(6'h04,1,0, 8,1,3'b000,3);
    v(6'h02,1,0, 0,0,3'b100,4); v(6'h02,1,0, 1,0,3'b000,4); v(6'h02,1,0, 9,1,3'b000,4);
    v(6'h00,1,0, 0,0,3'b100,5); v(6'h00,1,0, 1,0,3'b000,5); v(6'h00,1,1, 6,0,3'b000,5); v(6'h00,1,1, 7,1,3'b001,5);
    v(6'h00,0,0,13,0,3'b000,6); v(6'h00,0,0, 0,0,3'b000,6);
    opcode = 6'h00; mem_ready = 1;
    repeat (3) begin
      @(negedge clk);
      chk("reset_ctrl", 32'(ctrl), 0);
      chk("reset_state", 32'(state), 0);
      chk("reset_retired", 32'(instr_retired), 0);
      chk("reset_count", retired_count, 0);
    end
    @(posedge clk); #1 reset = 1;
    foreach (tbl[i]) begin
      opcode = tbl[i].op; mem_ready = tbl[i].mr; halt_req = tbl[i].hr;
      @(negedge clk);
      chk($sformatf("vec%0d_state", i), 32'(state), 32'(tbl[i].st));
      chk($sformatf("vec%0d_retired", i), 32'(instr_retired), 32'(tbl[i].ret));
      chk($sformatf("vec%0d_wr", i), 32'(wr), 32'(tbl[i].wr));
      chk($sformatf("vec%0d_count", i), retired_count, tbl[i].cnt);
      if (tbl[i].st == 8) chk("beq_ctrl", 32'(ctrl), 32'(exp_ctrl(8, 1'b1)));
      if (tbl[i].st == 9) chk("j_ctrl", 32'(ctrl), 32'(exp_ctrl(9, 1'b1)));
      if (tbl[i].st == 13) chk("halted", 32'(halted), 1);
      @(posedge clk); #1;
    end
    // illegal opcode: trap is absorbing, nothing else moves
    opcode = 6'h3F; mem_ready = 1;
    repeat (2) begin @(posedge clk); #1; end
    for (int i = 0; i < 20; i++) begin
      halt_req = i[0];
      @(negedge clk);
      chk("trap_ctrl", 32'(ctrl), 32'(18'h1));
      chk("trap_state", 32'(state), 12);
      chk("trap_count", retired_count, 6);
    end
    // async reset in the middle of a store wait
    @(posedge clk); #1 reset = 0; halt_req = 0;
    #2 reset = 1; opcode = 6'h2B; mem_ready = 1;
    repeat (2) begin @(posedge clk); #1; end
    mem_ready = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("sw_wait_mem_write", 32'({mem_write, iord}), 3);
    #1 reset = 0;
    #1 chk("abort_mem_write", 32'(mem_write), 0);
    chk("abort_ctrl", 32'(ctrl), 0);
    chk("abort_state", 32'(state), 0);
    @(posedge clk); #1 reset = 1; opcode = 6'h02; mem_ready = 1;
    @(negedge clk);
    chk("abort_fetch", 32'(state), 0);
    chk("abort_count", retired_count, 0);
    // sixteen jumps wrap the narrow counter
    repeat (48) @(posedge clk);
    #1;
    @(negedge clk);
    chk("wrap_count4", 32'(retired_count_4), 0);
    chk("wrap_count32", retired_count, 16);
    chk("wrap_state", 32'(state), 0);
    // randomized run against the route model
    @(posedge clk); #1 reset = 0;
    #2 reset = 1;
    mcnt = 0; tcyc = 0; halt_req = 0; mem_ready = 1'($urandom);
    new_instr();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      es = mhalt ? 13 : rt[ix];
      last = !mhalt && es != 12 && ix == rl - 1;
      eret = last && (es != 5 || mem_ready);
      chk("rnd_state", 32'(state), 32'(es));
      chk("rnd_ctrl", 32'(ctrl), 32'(exp_ctrl(es, mem_ready)));
      chk("rnd_retired", 32'(instr_retired), 32'(eret));
      chk("rnd_count", retired_count, mcnt);
      chk("rnd_count4", 32'(retired_count_4), 32'(mcnt[3:0]));
      nw = 0;
      if (mhalt) nw = !halt_req;
      else if (es == 12) tcyc++;
      else if ((es == 0 || es == 3 || es == 5) && !mem_ready) nw = 0;
      else if (last) begin
        if (halt_req) mhalt = 1;
        else nw = 1;
      end
      else ix++;
      if (eret) mcnt++;
      @(posedge clk); #1;
      mem_ready = $urandom_range(0, 3) != 0;
      halt_req = $urandom_range(0, 4) == 0;
      if (nw) new_instr();
      if (tcyc > 4) begin
        reset = 0;
        #2 reset = 1;
        mcnt = 0; tcyc = 0;
        new_instr();
      end
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
